// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-arbitration constants and types.
//   ptr_w(n)     : round-robin pointer width for n requesters ($clog2, minimum 1)
//   coll_policy_e: how a read that hits the same-cycle write address is handled
//   CollPolicy   : policy used by sdpram_arb
package mem_pkg;
  typedef enum logic {COLL_STALL_READ, COLL_READ_OLD} coll_policy_e;
  localparam coll_policy_e CollPolicy = COLL_STALL_READ;
  function automatic int ptr_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sdpram_arb_if.sv
// sdpram_arb_if: requester, response and RAM-side signals of sdpram_arb.
//   slave : arbiter view (takes requests and read data, drives ready/response/RAM controls)
//   master: requester/RAM-model view
interface sdpram_arb_if #(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32,
  parameter int NumReq       = 2
) ();
  logic [NumReq-1:0]              m_valid;
  logic [NumReq-1:0]              m_we;
  logic [NumReq*AddrBusWidth-1:0] m_addr;
  logic [NumReq*DataBusWidth-1:0] m_wdata;
  logic [NumReq-1:0]              m_ready;
  logic [NumReq-1:0]              rsp_valid;
  logic [DataBusWidth-1:0]        rsp_data;
  logic                           ram_rst;
  logic                           ram_we_a;
  logic [AddrBusWidth-1:0]        ram_addr_a;
  logic [DataBusWidth-1:0]        ram_wdata_a;
  logic                           ram_re_b;
  logic [AddrBusWidth-1:0]        ram_addr_b;
  logic [DataBusWidth-1:0]        ram_rdata_b;
  modport slave (
    input  m_valid, m_we, m_addr, m_wdata, ram_rdata_b,
    output m_ready, rsp_valid, rsp_data, ram_rst, ram_we_a, ram_addr_a, ram_wdata_a,
           ram_re_b, ram_addr_b
  );
  modport master (
    output m_valid, m_we, m_addr, m_wdata, ram_rdata_b,
    input  m_ready, rsp_valid, rsp_data, ram_rst, ram_we_a, ram_addr_a, ram_wdata_a,
           ram_re_b, ram_addr_b
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with pointer register.
//   i_req    : request vector      o_found: some request present
//   i_accept : candidate was taken; advance pointer past it
//   o_idx    : candidate index     o_gnt  : one-hot candidate
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = ptr_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic          o_found,
  output logic [PW-1:0] o_idx,
  output logic [N-1:0]  o_gnt
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_j;
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = PW'((int'(r_ptr) + k) % N);
      if (!o_found && i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end
  assign o_gnt = o_found ? (N'(1) << o_idx) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (i_accept) r_ptr <= PW'((int'(o_idx) + 1) % N);
endmodule

// File: rtl/sdpram_arb.sv
// sdpram_arb: arbitrates NumReq requesters onto a simple dual-port RAM
// (port A write, port B read, 1-cycle read latency), one write and one read per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : requests (m_*), responses (rsp_*), RAM controls (ram_*)
module sdpram_arb
  import mem_pkg::*;
#(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32,
  parameter int NumReq       = 2
) (
  input logic          clk,
  input logic          rst_n,
  sdpram_arb_if.slave  bus
);
  localparam int PW = ptr_w(NumReq);
  logic [AddrBusWidth-1:0] w_addr  [NumReq];
  logic [DataBusWidth-1:0] w_wdata [NumReq];
  logic [NumReq-1:0]       w_wgnt, w_rgnt;
  logic [PW-1:0]           w_widx, w_ridx, r_owner;
  logic                    w_wfound, w_rfound, w_wok, w_rok, w_coll, r_rsp;
  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign w_addr[i]  = bus.m_addr[i*AddrBusWidth +: AddrBusWidth];
    assign w_wdata[i] = bus.m_wdata[i*DataBusWidth +: DataBusWidth];
  end
  rr_arbiter #(.N(NumReq)) u_wr (
    .clk(clk), .rst_n(rst_n), .i_req(bus.m_valid & bus.m_we), .i_accept(w_wok),
    .o_found(w_wfound), .o_idx(w_widx), .o_gnt(w_wgnt)
  );
  rr_arbiter #(.N(NumReq)) u_rd (
    .clk(clk), .rst_n(rst_n), .i_req(bus.m_valid & ~bus.m_we), .i_accept(w_rok),
    .o_found(w_rfound), .o_idx(w_ridx), .o_gnt(w_rgnt)
  );
  // A read hitting the address being written this cycle waits one cycle so it sees the new data.
  assign w_coll = (CollPolicy == COLL_STALL_READ) && w_wfound && w_rfound &&
                  (w_addr[w_ridx] == w_addr[w_widx]);
  assign w_wok  = rst_n && w_wfound;
  assign w_rok  = rst_n && w_rfound && !w_coll;
  assign bus.m_ready     = (w_wok ? w_wgnt : '0) | (w_rok ? w_rgnt : '0);
  assign bus.ram_rst     = ~rst_n;
  assign bus.ram_we_a    = w_wok;
  assign bus.ram_addr_a  = w_addr[w_widx];
  assign bus.ram_wdata_a = w_wdata[w_widx];
  assign bus.ram_re_b    = w_rok;
  assign bus.ram_addr_b  = w_addr[w_ridx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rsp   <= 1'b0;
      r_owner <= '0;
    end else begin
      r_rsp <= w_rok;
      if (w_rok) r_owner <= w_ridx;
    end
  assign bus.rsp_valid = r_rsp ? (NumReq'(1) << r_owner) : '0;
  assign bus.rsp_data  = bus.ram_rdata_b;
endmodule

// File: tb/tb_sdpram_arb.sv
// tb_sdpram_arb: table-driven and scoreboard checks of sdpram_arb with a behavioural RAM.
module tb_sdpram_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;

  sdpram_arb_if #(.AddrBusWidth(32), .DataBusWidth(32), .NumReq(2)) bus ();
  sdpram_arb #(.AddrBusWidth(32), .DataBusWidth(32), .NumReq(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[8'h10] <= 32'hDEADBEEF;
      ram[8'h11] <= 32'h11111111;
    end else if (bus.ram_we_a) ram[bus.ram_addr_a[7:0]] <= bus.ram_wdata_a;
    if (bus.ram_re_b) bus.ram_rdata_b <= ram[bus.ram_addr_b[7:0]];
  end

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  typedef struct {
    logic [1:0] rv;
    logic [31:0] d;
  } rsp_t;
  rsp_t        q[$];
  logic [31:0] model [256];

  initial begin
    bit   due;
    rsp_t e;
    for (int i = 0; i < 256; i++) model[i] = '0;
    model[8'h10] = 32'hDEADBEEF;
    model[8'h11] = 32'h11111111;
    due = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        due = 0;
        chk("rsp_valid_in_reset", 64'(bus.rsp_valid), 0);
      end else begin
        if (due) begin
          e = q.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.rv));
          chk("rsp_data", 64'(bus.rsp_data), 64'(e.d));
        end else if (bus.rsp_valid != 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 0);
        due = 0;
        for (int k = 0; k < 2; k++)
          if (bus.m_valid[k] && bus.m_ready[k] && !bus.m_we[k]) begin
            q.push_back('{2'(1 << k), model[bus.m_addr[k*32 +: 8]]});
            due = 1;
          end
        for (int k = 0; k < 2; k++)
          if (bus.m_valid[k] && bus.m_ready[k] && bus.m_we[k])
            model[bus.m_addr[k*32 +: 8]] = bus.m_wdata[k*32 +: 32];
      end
    end
  end

  task automatic drive(logic [1:0] v, logic [1:0] we, logic [7:0] a0, logic [7:0] a1,
                       logic [31:0] d0, logic [31:0] d1);
    bus.m_valid = v;
    bus.m_we    = we;
    bus.m_addr  = {24'h0, a1, 24'h0, a0};
    bus.m_wdata = {d1, d0};
  endtask

  typedef struct {
    logic [1:0]  v, we;
    logic [7:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy;
    logic        wea, reb;
  } vec_t;
  vec_t tv[14];

  initial begin
    tv[0]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,    32'h0,    2'b00, 1'b0, 1'b0};
    tv[1]  = '{2'b01, 2'b00, 8'h10, 8'h00, 32'h0,    32'h0,    2'b01, 1'b0, 1'b1};
    tv[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,    32'h0,    2'b00, 1'b0, 1'b0};
    tv[3]  = '{2'b10, 2'b00, 8'h00, 8'h11, 32'h0,    32'h0,    2'b10, 1'b0, 1'b1};
    tv[4]  = '{2'b11, 2'b00, 8'h10, 8'h11, 32'h0,    32'h0,    2'b01, 1'b0, 1'b1};
    tv[5]  = '{2'b11, 2'b00, 8'h10, 8'h11, 32'h0,    32'h0,    2'b10, 1'b0, 1'b1};
    tv[6]  = '{2'b11, 2'b00, 8'h10, 8'h11, 32'h0,    32'h0,    2'b01, 1'b0, 1'b1};
    tv[7]  = '{2'b11, 2'b00, 8'h10, 8'h11, 32'h0,    32'h0,    2'b10, 1'b0, 1'b1};
    tv[8]  = '{2'b11, 2'b01, 8'h20, 8'h30, 32'h1234, 32'h0,    2'b11, 1'b1, 1'b1};
    tv[9]  = '{2'b11, 2'b01, 8'h40, 8'h40, 32'hCAFE, 32'h0,    2'b01, 1'b1, 1'b0};
    tv[10] = '{2'b10, 2'b00, 8'h00, 8'h40, 32'h0,    32'h0,    2'b10, 1'b0, 1'b1};
    tv[11] = '{2'b11, 2'b10, 8'h20, 8'h50, 32'h0,    32'hBEEF, 2'b11, 1'b1, 1'b1};
    tv[12] = '{2'b11, 2'b11, 8'h60, 8'h61, 32'h1,    32'h2,    2'b01, 1'b1, 1'b0};
    tv[13] = '{2'b11, 2'b11, 8'h60, 8'h61, 32'h1,    32'h2,    2'b10, 1'b1, 1'b0};

    drive(2'b11, 2'b00, 8'h10, 8'h11, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_m_ready", 64'(bus.m_ready), 0);
    chk("reset_ram_re_b", 64'(bus.ram_re_b), 0);
    chk("reset_ram_we_a", 64'(bus.ram_we_a), 0);
    chk("reset_ram_rst", 64'(bus.ram_rst), 1);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      drive(tv[i].v, tv[i].we, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_m_ready", i), 64'(bus.m_ready), 64'(tv[i].rdy));
      chk($sformatf("v%0d_ram_we_a", i), 64'(bus.ram_we_a), 64'(tv[i].wea));
      chk($sformatf("v%0d_ram_re_b", i), 64'(bus.ram_re_b), 64'(tv[i].reb));
    end

    // Read pointer now points at requester 1: reset lands in its grant cycle.
    @(posedge clk); #1;
    drive(2'b11, 2'b00, 8'h10, 8'h11, 0, 0);
    @(negedge clk);
    chk("pre_reset_m_ready", 64'(bus.m_ready), 64'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk("in_reset_m_ready", 64'(bus.m_ready), 0);
    chk("in_reset_ram_re_b", 64'(bus.ram_re_b), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_m_ready0", 64'(bus.m_ready), 64'(2'b01));
    chk("post_reset_addr_b", 64'(bus.ram_addr_b), 64'h10);
    @(posedge clk); #1;
    chk("post_reset_m_ready1", 64'(bus.m_ready), 64'(2'b10));
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
